timetag_stream_ctrl: RTL and testbench

Parametrised control/streaming block that sits between the event-tagger engine and the byte-wide UART transmitter. It arms and clears the tagger and buffers records in an internal FIFO of configurable depth. Each record is emitted as a framed byte stream (sync byte plus record bytes, MSB first) over a valid/ready byte handshake. It adds drop accounting on FIFO overflow and a clean drain-on-deactivate mode.

---
 rtl/timetag_pkg.sv | 20 ++
 rtl/tt_sync_fifo.sv | 71 +++++++
 rtl/timetag_stream_ctrl.sv | 176 +++++++++++++++++
 tb/tb_timetag_stream_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timetag_pkg.sv
// Shared types and helpers for the time-tag streaming controller.
package timetag_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_LOAD  = 3'd3,
        ST_SYNC  = 3'd4,
        ST_DATA  = 3'd5
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Bytes needed to carry a record plus its leading drop flag bit.
    function automatic int unsigned rec_bytes(input int unsigned record_w);
        return (record_w + 32'd8) / 32'd8;
    endfunction

endpackage

// File: rtl/tt_sync_fifo.sv
// Single-clock FIFO; read data is registered on pop and holds until the next pop.
module tt_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic [WIDTH-1:0] dout_r;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;

    assign full_s  = (level_r == LW'(DEPTH));
    assign empty_s = (level_r == {LW{1'b0}});
    // A push into a full FIFO is discarded even when a pop frees a slot this cycle.
    assign push_s  = push && !full_s;
    assign pop_s   = pop && !empty_s;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            dout_r   <= {WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                dout_r   <= mem_r[rd_ptr_r];
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1'b1);
                2'b01:   level_r <= level_r - LW'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign dout  = dout_r;
    assign full  = full_s;
    assign empty = empty_s;
    assign level = level_r;

endmodule

// File: rtl/timetag_stream_ctrl.sv
// Arms the tagger, buffers its records and streams each one as a framed,
// MSB-first byte sequence over a valid/ready handshake with drop accounting.
module timetag_stream_ctrl
    import timetag_pkg::*;
#(
    parameter int         N_CHANNELS = 4,
    parameter int         TS_WIDTH   = 43,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    parameter int         DROP_W     = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                activate,
    input  logic [N_CHANNELS+TS_WIDTH-1:0]      rec_data,
    input  logic                                rec_valid,
    output logic                                engine_en,
    output logic                                counter_clr,
    output logic [7:0]                          tx_byte,
    output logic                                tx_valid,
    input  logic                                tx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
    output logic [DROP_W-1:0]                   drop_count,
    output logic                                drop_pending,
    output logic                                busy
);

    localparam int RECORD_W  = N_CHANNELS + TS_WIDTH;
    localparam int REC_BYTES = int'(rec_bytes(RECORD_W));
    localparam int WORD_W    = REC_BYTES * 8;
    localparam int IDX_W     = $clog2(REC_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_BYTES - 1);

    state_t                          state_r;
    logic                            engine_en_r;
    logic                            tx_valid_r;
    logic [7:0]                      tx_byte_r;
    logic [IDX_W-1:0]                idx_r;
    logic [WORD_W-1:0]               shift_r;
    logic                            flag_r;
    logic [DROP_W-1:0]               drop_count_r;
    logic                            drop_pending_r;
    logic [WORD_W-1:0]               word_s;
    logic [RECORD_W-1:0]             head_s;
    logic                            push_s;
    logic                            pop_s;
    logic                            drop_s;
    logic                            xfer_s;
    logic                            full_s;
    logic                            empty_s;
    logic [$clog2(FIFO_DEPTH+1)-1:0] level_s;

    assign push_s = rec_valid && engine_en_r;
    assign pop_s  = (state_r == ST_LOAD);
    assign drop_s = push_s && full_s;
    assign xfer_s = tx_valid_r && tx_ready;

    tt_sync_fifo #(
        .WIDTH (RECORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   (rec_data),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level_s)
    );

    // Frame word: drop flag in the top bit, record right-aligned, zero padding between.
    always_comb begin
        word_s                 = {WORD_W{1'b0}};
        word_s[RECORD_W-1:0]   = head_s;
        word_s[WORD_W-1]       = flag_r;
    end

    // Control FSM with registered engine enable and byte-stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            engine_en_r <= 1'b0;
            tx_valid_r  <= 1'b0;
            tx_byte_r   <= 8'h00;
            idx_r       <= {IDX_W{1'b0}};
            shift_r     <= {WORD_W{1'b0}};
            flag_r      <= 1'b0;
        end else begin
            // Deactivation is sticky until IDLE so a drain cannot be re-armed midway.
            if (!activate) begin
                engine_en_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    engine_en_r <= 1'b0;
                    if (activate) begin
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    engine_en_r <= activate;
                    state_r     <= ST_RUN;
                end
                ST_RUN: begin
                    if (!empty_s) begin
                        state_r <= ST_LOAD;
                    end else if (!engine_en_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    flag_r     <= drop_pending_r;
                    tx_valid_r <= 1'b1;
                    tx_byte_r  <= SYNC_BYTE;
                    state_r    <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (xfer_s) begin
                        tx_byte_r <= word_s[WORD_W-1 -: 8];
                        shift_r   <= {word_s[WORD_W-9:0], 8'h00};
                        idx_r     <= {IDX_W{1'b0}};
                        state_r   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (xfer_s) begin
                        if (idx_r == LAST_IDX) begin
                            tx_valid_r <= 1'b0;
                            state_r    <= empty_s ? ST_RUN : ST_LOAD;
                        end else begin
                            tx_byte_r <= shift_r[WORD_W-1 -: 8];
                            shift_r   <= {shift_r[WORD_W-9:0], 8'h00};
                            idx_r     <= idx_r + IDX_W'(1'b1);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    tx_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Saturating drop counter and the pending flag carried into the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_r   <= {DROP_W{1'b0}};
            drop_pending_r <= 1'b0;
        end else if (state_r == ST_START) begin
            drop_count_r   <= {DROP_W{1'b0}};
            drop_pending_r <= 1'b0;
        end else begin
            if (drop_s && (drop_count_r != {DROP_W{1'b1}})) begin
                drop_count_r <= drop_count_r + DROP_W'(1'b1);
            end
            if (drop_s) begin
                drop_pending_r <= 1'b1;
            end else if (pop_s) begin
                drop_pending_r <= 1'b0;
            end
        end
    end

    assign engine_en    = engine_en_r;
    assign counter_clr  = (state_r == ST_START);
    assign busy         = (state_r != ST_IDLE);
    assign tx_valid     = tx_valid_r;
    assign tx_byte      = tx_byte_r;
    assign fifo_level   = level_s;
    assign drop_count   = drop_count_r;
    assign drop_pending = drop_pending_r;

endmodule

// File: tb/tb_timetag_stream_ctrl.sv
// Scoreboard bench: stimulus queues expected bytes, a monitor checks each transfer.
module tb_timetag_stream_ctrl;

    logic        clk;
    logic        reset;
    logic        activate;
    logic [46:0] rec_data;
    logic        rec_valid;
    logic        engine_en;
    logic        counter_clr;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  fifo_level;
    logic [1:0]  drop_count;
    logic        drop_pending;
    logic        busy;

    logic [7:0]  exp_q[$];
    int          n_vec;
    int          n_err;
    int          xfer_cnt;
    int          clr_cnt;
    logic        ready_level;
    logic        rand_en;
    logic        prev_stall;
    logic [7:0]  prev_byte;

    logic [46:0] recs [0:8] = '{
        47'h7FFF_0000_0001, 47'h0000_0000_00FF, 47'h5A5A_5A5A_5A5A,
        47'h0F0F_F0F0_1234, 47'h4000_0000_8001, 47'h3333_3333_3333,
        47'h1111_2222_3333, 47'h6666_7777_0000, 47'h0ABC_DEF0_1357
    };

    timetag_stream_ctrl #(
        .FIFO_DEPTH (4),
        .DROP_W     (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .activate     (activate),
        .rec_data     (rec_data),
        .rec_valid    (rec_valid),
        .engine_en    (engine_en),
        .counter_clr  (counter_clr),
        .tx_byte      (tx_byte),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count),
        .drop_pending (drop_pending),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sink side: either a fixed ready level or a random back-pressure pattern.
    always @(posedge clk) begin
        #2;
        tx_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_level;
    end

    // Monitor: pops the scoreboard on each transfer and checks hold-while-stalled.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_vec++;
                if (!(tx_valid && tx_byte == prev_byte)) begin
                    n_err++;
                    $display("FAIL hold: valid=%0b byte=%02h, required valid=1 byte=%02h",
                             tx_valid, tx_byte, prev_byte);
                end
            end
            if (tx_valid && tx_ready) begin
                xfer_cnt++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_byte: got %02h with nothing expected", tx_byte);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_byte !== e) begin
                        n_err++;
                        $display("FAIL stream_byte: got %02h, required %02h", tx_byte, e);
                    end
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_byte  = tx_byte;
        end
        if (counter_clr) clr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send_rec(input logic [46:0] r);
        rec_data  = r;
        rec_valid = 1'b1;
        tick();
        rec_valid = 1'b0;
    endtask

    task automatic push_frame(input logic [46:0] r, input logic flag);
        logic [47:0] w;
        w = {flag, r};
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 6; i++) exp_q.push_back(w[47-8*i -: 8]);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int snap;
        n_vec = 0; n_err = 0; xfer_cnt = 0; clr_cnt = 0;
        reset = 1'b1; activate = 1'b0; rec_valid = 1'b0; rec_data = 47'd0;
        ready_level = 1'b1; rand_en = 1'b0; tx_ready = 1'b0; prev_stall = 1'b0;
        repeat (3) tick();
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_engine_en", 64'(engine_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_counter_clr", 64'(counter_clr), 64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        check("rst_drop_count", 64'(drop_count), 64'd0);

        // Single record, free-running sink
        reset = 1'b0; activate = 1'b1;
        tick();
        check("start_clr", 64'(counter_clr), 64'd1);
        check("start_engine_en", 64'(engine_en), 64'd0);
        tick();
        check("run_clr", 64'(counter_clr), 64'd0);
        check("run_engine_en", 64'(engine_en), 64'd1);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        exp_q.push_back(8'h56); exp_q.push_back(8'h78); exp_q.push_back(8'h9A);
        exp_q.push_back(8'hBC);
        send_rec(47'h1234_5678_9ABC);
        check("lat_level", 64'(fifo_level), 64'd1);
        tick();
        check("lat_load_valid", 64'(tx_valid), 64'd0);
        tick();
        check("lat_sync_valid", 64'(tx_valid), 64'd1);
        check("lat_sync_byte", 64'(tx_byte), 64'hA5);
        wait_drain("t1_drain", 100);
        check("t1_level", 64'(fifo_level), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_clr_pulses", 64'(clr_cnt), 64'd1);

        // Overflow with a stalled sink
        ready_level = 1'b0;
        tick();
        push_frame(recs[0], 1'b0);
        push_frame(recs[1], 1'b1);
        for (int i = 2; i < 5; i++) push_frame(recs[i], 1'b0);
        for (int i = 0; i < 6; i++) send_rec(recs[i]);
        check("ovf_level", 64'(fifo_level), 64'd4);
        check("ovf_drop_count", 64'(drop_count), 64'd1);
        check("ovf_drop_pending", 64'(drop_pending), 64'd1);
        check("ovf_stall_byte", 64'(tx_byte), 64'hA5);
        ready_level = 1'b1;
        wait_drain("t2_drain", 200);
        check("t2_level", 64'(fifo_level), 64'd0);
        check("t2_drop_pending", 64'(drop_pending), 64'd0);

        // Random back-pressure over three frames
        rand_en = 1'b1;
        for (int i = 6; i < 9; i++) push_frame(recs[i], 1'b0);
        send_rec(recs[6]);
        repeat (4) tick();
        send_rec(recs[7]);
        send_rec(recs[8]);
        wait_drain("t3_drain", 400);
        rand_en = 1'b0;
        tick();

        // Deactivate with records queued: drain, ignore late records, return to IDLE
        ready_level = 1'b0;
        tick();
        for (int i = 2; i < 5; i++) push_frame(recs[i], 1'b0);
        for (int i = 2; i < 5; i++) send_rec(recs[i]);
        tick();
        activate = 1'b0;
        tick();
        check("deact_engine_en", 64'(engine_en), 64'd0);
        check("deact_busy", 64'(busy), 64'd1);
        send_rec(recs[5]);
        check("deact_ignored_level", 64'(fifo_level), 64'd2);
        check("deact_drop_count", 64'(drop_count), 64'd1);
        ready_level = 1'b1;
        wait_idle("t4_idle", 300);
        check("t4_frames_done", 64'(exp_q.size()), 64'd0);

        // Drop counter saturation, then cleared by a fresh START
        activate = 1'b1;
        tick();
        check("t5_start_clr", 64'(counter_clr), 64'd1);
        tick();
        check("t5_drop_cleared", 64'(drop_count), 64'd0);
        check("t5_clr_pulses", 64'(clr_cnt), 64'd2);
        ready_level = 1'b0;
        tick();
        push_frame(recs[0], 1'b0);
        push_frame(recs[1], 1'b1);
        for (int i = 2; i < 5; i++) push_frame(recs[i], 1'b0);
        for (int i = 0; i < 9; i++) send_rec(recs[i]);
        check("sat_drop_count", 64'(drop_count), 64'd3);
        check("sat_level", 64'(fifo_level), 64'd4);
        activate = 1'b0; ready_level = 1'b1;
        wait_idle("t5_idle", 400);
        check("sat_hold", 64'(drop_count), 64'd3);
        check("t5_frames_done", 64'(exp_q.size()), 64'd0);
        activate = 1'b1;
        tick();
        tick();
        check("react_drop_count", 64'(drop_count), 64'd0);
        check("react_clr_pulses", 64'(clr_cnt), 64'd3);

        // Reset in the middle of a frame
        ready_level = 1'b0;
        tick();
        exp_q.push_back(8'hA5); exp_q.push_back(8'h0F); exp_q.push_back(8'h0F);
        for (int i = 3; i < 9; i++) send_rec(recs[i]);
        check("t6_pre_drop", 64'(drop_count), 64'd1);
        ready_level = 1'b1;
        repeat (3) tick();
        ready_level = 1'b0;
        check("t6_mid_byte", 64'(tx_byte), 64'hF0);
        reset = 1'b1; activate = 1'b0;
        tick();
        check("t6_tx_valid", 64'(tx_valid), 64'd0);
        check("t6_level", 64'(fifo_level), 64'd0);
        check("t6_drop_count", 64'(drop_count), 64'd0);
        check("t6_engine_en", 64'(engine_en), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        snap = xfer_cnt;
        reset = 1'b0; ready_level = 1'b1;
        repeat (20) tick();
        check("t6_no_bytes", 64'(xfer_cnt), 64'(snap));
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
